multiplier_datapath_taint_track_word: RTL
=========================================

// Module: multiplier_datapath_taint_track_word
// PURPOSE
//  Datapath for the sequential shift-add multiplier with word-level taint tracking.
//  Consumes the controller's load/clear/shift strobes and their taint bits.
//  Holds the multiplicand, the multiplier and the running-sum registers.
//  Returns multiplierReg plus its taint to the controller, and exposes the product word with its taint.
// PARAMETERS
//  WIDTH  4  operand width in bits; product is 2*WIDTH bits
// PORTS
//  clk              in   1        clock; all state updates on posedge
//  rst              in   1        reset, asynchronous, active-high
//  multiplicand     in   WIDTH    operand A, sampled on mdld
//  multiplicand_t   in   1        taint of multiplicand
//  multiplier       in   WIDTH    operand B, sampled on mrld
//  multiplier_t     in   1        taint of multiplier
//  rsload / _t      in   1 / 1    add multiplicand into running-sum upper half; taint
//  rsclear / _t     in   1 / 1    clear running sum; taint
//  rsshr / _t       in   1 / 1    shift running sum right by 1; taint
//  mrld / _t        in   1 / 1    load multiplierReg; taint
//  mdld / _t        in   1 / 1    load multiplicandReg; taint
//  multiplierReg    out  WIDTH    held multiplier, indexed by the controller
//  multiplierReg_t  out  1        taint of multiplierReg
//  product          out  2*WIDTH  running sum bits [2W-1:0]
//  product_t        out  1        taint of running sum
// BEHAVIOUR
//  Reset
//   - rst=1 asynchronously zeroes mdReg, multiplierReg and rs[2W:0].
//   - All taint registers go to 0 at the same time.
//   - Reset mid-operation discards all partial sums.
//  mdReg and multiplierReg
//   - mdld=1: mdReg <= multiplicand; mdReg_t <= multiplicand_t | mdld_t.
//   - mdld=0: mdReg holds; mdReg_t <= mdReg_t | mdld_t.
//   - multiplierReg follows the same rules with mrld/mrld_t.
//   - multiplierReg never shifts.
//  Running sum rs (2W+1 bits; top bit is the carry)
//   - Operation is one-hot by priority: rsclear > rsload > rsshr > hold.
//   - clear: rs <= 0; base_t = 0.
//   - load: rs[2W:W] <= {1'b0, rs[2W-1:W]} + {1'b0, mdReg}; rs[W-1:0] holds; base_t = rs_t | mdReg_t.
//   - shr: rs <= {1'b0, rs[2W:1]}; base_t = rs_t.
//   - hold: base_t = rs_t.
//   - rs_t <= base_t | rsclear_t | rsload_t | rsshr_t.
//   - A tainted strobe taints rs even when the strobe is deasserted: its value decided whether rs changed.
//  Outputs
//   - All outputs are registered and take effect one cycle after the strobe.
//   - product = rs[2W-1:0]; product_t = rs_t.
//   - Load never overflows: the carry bit is always shifted out before the next load.
//  Protocol
//   - No handshake.
//   - Several strobes in one cycle resolve by the priority above; the loser's taint is still ORed in.
// CONFIGURATION
//  MULT_DP_PRODUCT_LATCH_EN defined:
//   - Adds inputs productDone and productDone_t.
//   - Adds outputs productOut[2W-1:0], productOut_t and productValid.
//   - On productDone=1: productOut <= rs_next[2W-1:0] (the post-shift value); productOut_t <= rs_t_next | productDone_t; productValid <= 1.
//   - productValid clears on mdld=1.
//   - When productDone=0, productOut_t still ORs in productDone_t.
//   - All three registers reset to 0.
//  MULT_DP_PRODUCT_LATCH_EN undefined:
//   - None of these ports or registers exist.
//   - Core behaviour is unchanged.
// STRUCTURE
//  Package multiplier_taint_pkg:
//   - rs_op_e {RS_HOLD, RS_CLEAR, RS_LOAD, RS_SHR};
//   - function rs_op_sel(clear, load, shr) implementing the priority above;
//   - localparam-style helper PROD_W(w) = 2*w.
//  Sub-module running_sum_reg_taint holds rs plus rs_t and implements the op and taint rules.
//  The top level holds the operand registers and the optional product latch.
// TESTING
//  - Reset: assert rst mid-cycle with nonzero state -> all outputs and taints read 0 immediately, before the next clk.
//  - Multiply, WIDTH=4, MD=13, MR=11:
//     - Drive INIT, then SHIFT, then LOAD/NOP for each bit b0..b3, then FINAL.
//     - Expect product=8'h8F (143) and product_t=0.
//  - Operand taint: multiplier_t=1 on mrld -> multiplierReg_t=1 the next cycle and stays 1 until a clean mrld.
//  - Strobe taint: rsshr=0, rsshr_t=1 for one cycle -> rs unchanged, product_t=1 from then on.
//  - Priority: rsclear=1 and rsload=1 with rs=8'h5A -> rs=0; rs_t = rsclear_t | rsload_t.
//  - Latch (MULT_DP_PRODUCT_LATCH_EN): 15*15 -> productOut=8'hE1 and productValid=1 after FINAL; productValid clears on the next mdld.

Source files
------------

// File: rtl/multiplier_taint_pkg.sv
// Shared types and helpers for the shift-add multiplier datapath with word-level taint.
// Running-sum operation encoding, strobe priority and product-width helper.
package multiplier_taint_pkg;

    typedef enum logic [1:0] {RS_HOLD, RS_CLEAR, RS_LOAD, RS_SHR} rs_op_e;

    // Clear wins over load, load wins over shift; nothing asserted means hold.
    function automatic rs_op_e rs_op_sel(input logic clear, input logic load, input logic shr);
        if (clear)
            return RS_CLEAR;
        else if (load)
            return RS_LOAD;
        else if (shr)
            return RS_SHR;
        else
            return RS_HOLD;
    endfunction

    function automatic int PROD_W(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/running_sum_reg_taint.sv
// Running-sum register rs[2W:0] (top bit is the add carry) plus its word-level taint.
// With MULT_DP_PRODUCT_LATCH_EN defined, the next-state value and taint are also exported.
module running_sum_reg_taint
    import multiplier_taint_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rsclear,
    input  logic                        rsclear_t,
    input  logic                        rsload,
    input  logic                        rsload_t,
    input  logic                        rsshr,
    input  logic                        rsshr_t,
    input  logic [WIDTH-1:0]            md,
    input  logic                        md_t,
`ifdef MULT_DP_PRODUCT_LATCH_EN
    output logic [PROD_W(WIDTH)-1:0]    rs_next_prod,
    output logic                        rs_t_next,
`endif
    output logic [PROD_W(WIDTH)-1:0]    product,
    output logic                        product_t
);

    localparam int PW = PROD_W(WIDTH);

    logic [PW:0] rs;
    logic        rs_t;
    logic [PW:0] rs_nxt;
    logic        base_t;
    logic        rs_t_nxt;
    rs_op_e      op;

    always_comb begin
        rs_nxt = rs;
        base_t = rs_t;
        op     = rs_op_sel(rsclear, rsload, rsshr);
        case (op)
            RS_CLEAR: begin
                rs_nxt = '0;
                base_t = 1'b0;
            end
            RS_LOAD: begin
                rs_nxt[PW:WIDTH] = {1'b0, rs[PW-1:WIDTH]} + {1'b0, md};
                base_t           = rs_t | md_t;
            end
            RS_SHR: begin
                rs_nxt = {1'b0, rs[PW:1]};
            end
            default: ;
        endcase
        // Every strobe's taint counts, selected or not: its value chose the operation.
        rs_t_nxt = base_t | rsclear_t | rsload_t | rsshr_t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs   <= '0;
            rs_t <= 1'b0;
        end else begin
            rs   <= rs_nxt;
            rs_t <= rs_t_nxt;
        end
    end

    assign product   = rs[PW-1:0];
    assign product_t = rs_t;
`ifdef MULT_DP_PRODUCT_LATCH_EN
    assign rs_next_prod = rs_nxt[PW-1:0];
    assign rs_t_next    = rs_t_nxt;
`endif

endmodule

// File: rtl/multiplier_datapath_taint_track_word.sv
// Shift-add multiplier datapath with word-level taint: operand registers plus running sum.
// Optional product latch is enabled by defining MULT_DP_PRODUCT_LATCH_EN.
module multiplier_datapath_taint_track_word
    import multiplier_taint_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            multiplicand,
    input  logic                        multiplicand_t,
    input  logic [WIDTH-1:0]            multiplier,
    input  logic                        multiplier_t,
    input  logic                        rsload,
    input  logic                        rsload_t,
    input  logic                        rsclear,
    input  logic                        rsclear_t,
    input  logic                        rsshr,
    input  logic                        rsshr_t,
    input  logic                        mrld,
    input  logic                        mrld_t,
    input  logic                        mdld,
    input  logic                        mdld_t,
`ifdef MULT_DP_PRODUCT_LATCH_EN
    input  logic                        productDone,
    input  logic                        productDone_t,
    output logic [PROD_W(WIDTH)-1:0]    productOut,
    output logic                        productOut_t,
    output logic                        productValid,
`endif
    output logic [WIDTH-1:0]            multiplierReg,
    output logic                        multiplierReg_t,
    output logic [PROD_W(WIDTH)-1:0]    product,
    output logic                        product_t
);

    logic [WIDTH-1:0] md_reg;
    logic             md_reg_t;

    // A tainted load strobe taints the register even on cycles it does not load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_reg          <= '0;
            md_reg_t        <= 1'b0;
            multiplierReg   <= '0;
            multiplierReg_t <= 1'b0;
        end else begin
            if (mdld) begin
                md_reg   <= multiplicand;
                md_reg_t <= multiplicand_t | mdld_t;
            end else begin
                md_reg_t <= md_reg_t | mdld_t;
            end
            if (mrld) begin
                multiplierReg   <= multiplier;
                multiplierReg_t <= multiplier_t | mrld_t;
            end else begin
                multiplierReg_t <= multiplierReg_t | mrld_t;
            end
        end
    end

`ifdef MULT_DP_PRODUCT_LATCH_EN
    logic [PROD_W(WIDTH)-1:0] rs_next_prod;
    logic                     rs_t_next;
`endif

    running_sum_reg_taint #(.WIDTH(WIDTH)) u_rs (
        .clk       (clk),
        .rst       (rst),
        .rsclear   (rsclear),
        .rsclear_t (rsclear_t),
        .rsload    (rsload),
        .rsload_t  (rsload_t),
        .rsshr     (rsshr),
        .rsshr_t   (rsshr_t),
        .md        (md_reg),
        .md_t      (md_reg_t),
`ifdef MULT_DP_PRODUCT_LATCH_EN
        .rs_next_prod (rs_next_prod),
        .rs_t_next    (rs_t_next),
`endif
        .product   (product),
        .product_t (product_t)
    );

`ifdef MULT_DP_PRODUCT_LATCH_EN
    // Captures the post-shift sum so the final shift and the latch share one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            productOut   <= '0;
            productOut_t <= 1'b0;
            productValid <= 1'b0;
        end else if (productDone) begin
            productOut   <= rs_next_prod;
            productOut_t <= rs_t_next | productDone_t;
            productValid <= 1'b1;
        end else begin
            productOut_t <= productOut_t | productDone_t;
            if (mdld)
                productValid <= 1'b0;
        end
    end
`endif

endmodule
